sram_readback_port: RTL and testbench

//  C64-side read path into the 128 KiB video SRAM: the C64 loads a pointer, starts a fetch, then reads the byte back.

---
 rtl/vg64_pkg.sv | 36 +++
 rtl/c64_bus_sync.sv | 65 ++++++
 rtl/sram_readback_port.sv | 187 ++++++++++++++++++
 tb/tb_sram_readback_port.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vg64_pkg.sv
// Shared constants for the C64-side SRAM readback port: register map,
// control-register bit positions and fetch FSM encoding.
package vg64_pkg;

  localparam logic [15:0] IO1_BASE = 16'hDE04;

  localparam logic [1:0] REG_RDLSB  = 2'd0;
  localparam logic [1:0] REG_RDMSB  = 2'd1;
  localparam logic [1:0] REG_CTL    = 2'd2;
  localparam logic [1:0] REG_RDDATA = 2'd3;

  // CTL bit 7 reads as busy and, when written as 1, starts a fetch
  localparam int CTL_BANK    = 0;
  localparam int CTL_AUTOINC = 1;
  localparam int CTL_ERR     = 6;
  localparam int CTL_BUSY    = 7;
  localparam int CTL_START   = 7;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] ctl_byte(input logic busy, input logic err,
                                          input logic autoinc, input logic bank);
    logic [7:0] b;
    b              = 8'h00;
    b[CTL_BUSY]    = busy;
    b[CTL_ERR]     = err;
    b[CTL_AUTOINC] = autoinc;
    b[CTL_BANK]    = bank;
    return b;
  endfunction

endpackage

// File: rtl/c64_bus_sync.sv
// Brings the asynchronous C64 bus into the clk100 domain: PHI2/RW synchronisers,
// PHI2 edge pulses and a registered snapshot of address/data taken while PHI2 is high.
module c64_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        i_64clk,
  input  logic        i_64rw,
  input  logic [15:0] i_64addr,
  input  logic [7:0]  i_64data,
  output logic        phi2_o,
  output logic        phi2_rise_o,
  output logic        phi2_fall_o,
  output logic        rw_o,
  output logic [15:0] addr_o,
  output logic [7:0]  data_o
);

  logic [SYNC_STAGES-1:0] phi2_sync_q;
  logic [SYNC_STAGES-1:0] rw_sync_q;
  logic                   phi2_prev_q;
  logic                   rw_q;
  logic [15:0]            addr_q;
  logic [7:0]             data_q;
  logic                   phi2_s;
  logic                   cap_en;

  assign phi2_s = phi2_sync_q[SYNC_STAGES-1];
  // Snapshot stops as soon as the earlier stage sees PHI2 low, so the value
  // held at the fall pulse was taken while the bus was still valid.
  assign cap_en = phi2_sync_q[SYNC_STAGES-1] & phi2_sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      phi2_sync_q <= '0;
      rw_sync_q   <= '0;
      phi2_prev_q <= 1'b0;
    end else begin
      phi2_sync_q <= {phi2_sync_q[SYNC_STAGES-2:0], i_64clk};
      rw_sync_q   <= {rw_sync_q[SYNC_STAGES-2:0], i_64rw};
      phi2_prev_q <= phi2_s;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      rw_q   <= 1'b0;
      addr_q <= 16'h0000;
      data_q <= 8'h00;
    end else if (cap_en) begin
      rw_q   <= rw_sync_q[SYNC_STAGES-1];
      addr_q <= i_64addr;
      data_q <= i_64data;
    end
  end

  assign phi2_o      = phi2_s;
  assign phi2_rise_o = phi2_s & ~phi2_prev_q;
  assign phi2_fall_o = ~phi2_s & phi2_prev_q;
  assign rw_o        = rw_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;

endmodule

// File: rtl/sram_readback_port.sv
// C64 read path into video SRAM: pointer/control registers in IO1, a single
// outstanding arbiter fetch with timeout, and the cart data bus read mux.
module sram_readback_port
  import vg64_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = IO1_BASE,
  parameter int          ADDR_W      = 17,
  parameter int          TIMEOUT     = 64,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              i_64clk,
  input  logic              i_64rw,
  input  logic [15:0]       i_64addr,
  input  logic [7:0]        i_64data,
  output logic [7:0]        o_64data,
  output logic              o_64data_oe,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic              i_gnt,
  input  logic              i_rvalid,
  input  logic [7:0]        i_rdata,
  output logic              o_busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic        phi2, phi2_rise, phi2_fall, bus_rw;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;

  c64_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk100     (clk100),
    .rst        (rst),
    .i_64clk    (i_64clk),
    .i_64rw     (i_64rw),
    .i_64addr   (i_64addr),
    .i_64data   (i_64data),
    .phi2_o     (phi2),
    .phi2_rise_o(phi2_rise),
    .phi2_fall_o(phi2_fall),
    .rw_o       (bus_rw),
    .addr_o     (bus_addr),
    .data_o     (bus_data)
  );

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        data_q, data_d;
  logic              autoinc_q, autoinc_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              rd_win_q, rd_win_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [15:0] rel_addr;
  logic [1:0]  reg_off;
  logic        hit, wr_stb, rd_stb, busy, tmo_last;
  logic [7:0]  rd_mux;

  assign rel_addr = bus_addr - BASE_ADDR;
  assign hit      = (rel_addr[15:2] == 14'd0);
  assign reg_off  = rel_addr[1:0];
  assign wr_stb   = phi2_fall & ~bus_rw & hit;
  assign rd_stb   = phi2_fall & bus_rw & hit;
  assign busy     = (state_q != FETCH_IDLE);
  assign tmo_last = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_IDLE;
      ptr_q     <= '0;
      raddr_q   <= '0;
      data_q    <= 8'h00;
      autoinc_q <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      rd_win_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      raddr_q   <= raddr_d;
      data_q    <= data_d;
      autoinc_q <= autoinc_d;
      err_q     <= err_d;
      start_q   <= start_d;
      rd_win_q  <= rd_win_d;
      tmo_q     <= tmo_d;
    end
  end

  // Register file: C64 writes and the RDDATA read side effect.
  always_comb begin
    ptr_d     = ptr_q;
    autoinc_d = autoinc_q;
    start_d   = 1'b0;
    rd_win_d  = rd_win_q;

    if (!phi2) begin
      rd_win_d = 1'b0;
    end else if (phi2_rise) begin
      rd_win_d = 1'b1;
    end

    if (wr_stb) begin
      case (reg_off)
        REG_RDLSB: ptr_d[7:0]  = bus_data;
        REG_RDMSB: ptr_d[15:8] = bus_data;
        REG_CTL: begin
          ptr_d[ADDR_W-1] = bus_data[CTL_BANK];
          autoinc_d       = bus_data[CTL_AUTOINC];
          start_d         = bus_data[CTL_START];
        end
        default: ;
      endcase
    end else if (rd_stb && reg_off == REG_RDDATA) begin
      ptr_d   = ptr_q + ADDR_W'(1);
      start_d = autoinc_q;
    end
  end

  // Fetch FSM; the timeout counter runs from REQ entry across REQ and WAIT.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    case (state_q)
      FETCH_IDLE: begin
        if (start_q) begin
          state_d = FETCH_REQ;
          raddr_d = ptr_q;
          err_d   = 1'b0;
          tmo_d   = '0;
        end
      end
      FETCH_REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (i_gnt && i_rvalid) begin
          data_d  = i_rdata;
          state_d = FETCH_IDLE;
        end else if (tmo_last) begin
          data_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = FETCH_IDLE;
        end else if (i_gnt) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (i_rvalid) begin
          data_d  = i_rdata;
          state_d = FETCH_IDLE;
        end else if (tmo_last) begin
          data_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    case (reg_off)
      REG_RDLSB: rd_mux = ptr_q[7:0];
      REG_RDMSB: rd_mux = ptr_q[15:8];
      REG_CTL:   rd_mux = ctl_byte(busy, err_q, autoinc_q, ptr_q[ADDR_W-1]);
      default:   rd_mux = data_q;
    endcase
  end

  assign o_64data_oe = phi2 & rd_win_q & bus_rw & hit;
  assign o_64data    = o_64data_oe ? rd_mux : 8'h00;
  assign o_req       = (state_q == FETCH_REQ);
  assign o_raddr     = raddr_q;
  assign o_busy      = busy;

endmodule

// File: tb/tb_sram_readback_port.sv
// Randomised and directed bench for sram_readback_port; the bench plays both
// the C64 bus master and the SRAM arbiter and predicts register contents.
module tb_sram_readback_port;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        i_64clk, i_64rw;
  logic [15:0] i_64addr;
  logic [7:0]  i_64data;
  logic [7:0]  o_64data;
  logic        o_64data_oe;
  logic        o_req;
  logic [16:0] o_raddr;
  logic        i_gnt, i_rvalid;
  logic [7:0]  i_rdata;
  logic        o_busy;

  always #5 clk100 = ~clk100;

  sram_readback_port dut (
    .clk100     (clk100),
    .rst        (rst),
    .i_64clk    (i_64clk),
    .i_64rw     (i_64rw),
    .i_64addr   (i_64addr),
    .i_64data   (i_64data),
    .o_64data   (o_64data),
    .o_64data_oe(o_64data_oe),
    .o_req      (o_req),
    .o_raddr    (o_raddr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .o_busy     (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: 17-bit pointer as a plain integer modulo 2^17.
  int         m_ptr;
  int         m_autoinc;
  int         m_err;
  logic [7:0] m_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100);
      #1;
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_autoinc = 0;
    m_err     = 0;
    m_data    = 8'h00;
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           output logic [7:0] rdv, output logic oe_any);
    i_64addr = a;
    i_64rw   = rw;
    i_64data = wd;
    tick(4);
    i_64clk = 1'b1;
    oe_any  = 1'b0;
    rdv     = 8'h00;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (o_64data_oe) oe_any = 1'b1;
      if (c == 15) rdv = o_64data;
    end
    i_64clk = 1'b0;
    tick(4);
    if (rw) $display("bus rd %04h -> %02h oe=%0b", a, rdv, oe_any);
    else    $display("bus wr %04h <= %02h", a, wd);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    logic       oe;
    bus_cycle(a, 1'b0, d, dummy, oe);
    case (a)
      16'hDE04: m_ptr = (m_ptr / 256) * 256 + int'(d);
      16'hDE05: m_ptr = (m_ptr / 65536) * 65536 + int'(d) * 256 + (m_ptr % 256);
      16'hDE06: begin
        m_ptr     = (int'(d) % 2) * 65536 + (m_ptr % 65536);
        m_autoinc = (int'(d) / 2) % 2;
      end
      default: ;
    endcase
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    logic       oe;
    logic       hit;
    hit = (a >= 16'hDE04) && (a <= 16'hDE07);
    case (a)
      16'hDE04: exp = 8'(m_ptr % 256);
      16'hDE05: exp = 8'((m_ptr / 256) % 256);
      16'hDE06: exp = 8'(m_err * 64 + m_autoinc * 2 + m_ptr / 65536);
      16'hDE07: exp = m_data;
      default:  exp = 8'h00;
    endcase
    bus_cycle(a, 1'b1, 8'h00, d, oe);
    check_val({tag, "_oe"}, 32'(oe), 32'(hit));
    if (hit) check_val(tag, 32'(d), 32'(exp));
    if (a == 16'hDE07) m_ptr = (m_ptr + 1) % 131072;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!o_req && n < 40) begin
      tick(1);
      n++;
    end
    check_val("req_rise", 32'(o_req), 32'd1);
  endtask

  task automatic pulse_gnt(input logic with_rv, input logic [7:0] d);
    i_gnt    = 1'b1;
    i_rvalid = with_rv;
    i_rdata  = d;
    tick(1);
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    check_val("req_drop", 32'(o_req), 32'd0);
  endtask

  task automatic pulse_rv(input logic [7:0] d);
    i_rvalid = 1'b1;
    i_rdata  = d;
    tick(1);
    i_rvalid = 1'b0;
  endtask

  task automatic do_fetch(input int gd, input int rvd, input logic [7:0] rdv, input string tag);
    wait_req();
    check_val({tag, "_raddr"}, 32'(o_raddr), 32'(m_ptr));
    tick(gd);
    pulse_gnt(rvd == 0, rdv);
    if (rvd > 0) begin
      tick(rvd - 1);
      check_val({tag, "_busy"}, 32'(o_busy), 32'd1);
      pulse_rv(rdv);
    end
    check_val({tag, "_done"}, 32'(o_busy), 32'd0);
    m_data = rdv;
    m_err  = 0;
    $display("fetch %s raddr=%05h gnt_dly=%0d rv_dly=%0d rdata=%02h", tag, o_raddr, gd, rvd, rdv);
  endtask

  initial begin
    int          cnt;
    int          lat;
    logic [16:0] held;
    logic [15:0] a;
    logic [7:0]  rv;

    rst = 1'b0; i_64clk = 1'b0; i_64rw = 1'b1; i_64addr = 16'h0000; i_64data = 8'h00;
    i_gnt = 1'b0; i_rvalid = 1'b0; i_rdata = 8'h00;
    #2 rst = 1'b1;
    tick(3);
    check_val("rst_req", 32'(o_req), 32'd0);
    check_val("rst_raddr", 32'(o_raddr), 32'd0);
    check_val("rst_oe", 32'(o_64data_oe), 32'd0);
    check_val("rst_data", 32'(o_64data), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    model_reset();
    tick(2);
    rd(16'hDE06, "rst_ctl");
    rd(16'hDE07, "rst_rddata");

    // Basic fetch from bank 1
    wr(16'hDE04, 8'h34);
    wr(16'hDE05, 8'h12);
    wr(16'hDE06, 8'h81);
    do_fetch(5, 0, 8'hA5, "basic");
    rd(16'hDE06, "basic_ctl");
    rd(16'hDE07, "basic_rddata");

    // Auto-increment across the 17-bit wrap
    wr(16'hDE04, 8'hFF);
    wr(16'hDE05, 8'hFF);
    wr(16'hDE06, 8'h03);
    rd(16'hDE07, "ai_rddata");
    do_fetch(2, 1, 8'h3C, "ai_wrap");
    rd(16'hDE06, "ai_ctl");
    rd(16'hDE04, "ai_lsb");
    rd(16'hDE05, "ai_msb");

    // Arbiter never grants: request must be abandoned after the timeout
    wr(16'hDE06, 8'h80);
    wait_req();
    cnt = 0;
    while (o_req && cnt < 200) begin
      cnt++;
      tick(1);
    end
    check_val("tmo_req_cycles", 32'(cnt), 32'd64);
    check_val("tmo_busy", 32'(o_busy), 32'd0);
    m_data = 8'hFF;
    m_err  = 1;
    rd(16'hDE07, "tmo_rddata");
    rd(16'hDE06, "tmo_ctl");

    // Second start while busy is dropped
    wr(16'hDE06, 8'h80);
    wait_req();
    check_val("dbl_raddr", 32'(o_raddr), 32'(m_ptr));
    wr(16'hDE06, 8'h80);
    check_val("dbl_still_req", 32'(o_req), 32'd1);
    pulse_gnt(1'b1, 8'h77);
    m_data = 8'h77;
    m_err  = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (o_req) cnt++;
    end
    check_val("dbl_no_second_req", 32'(cnt), 32'd0);
    rd(16'hDE07, "dbl_rddata");

    // Pointer rewrite while the fetch sits in WAIT
    wr(16'hDE04, 8'h5B);
    wr(16'hDE06, 8'h81);
    wait_req();
    held = o_raddr;
    check_val("wait_raddr", 32'(held), 32'(m_ptr));
    pulse_gnt(1'b0, 8'h00);
    wr(16'hDE04, 8'hC6);
    check_val("wait_raddr_held", 32'(o_raddr), 32'(held));
    check_val("wait_busy", 32'(o_busy), 32'd1);
    pulse_rv(8'h9E);
    check_val("wait_done", 32'(o_busy), 32'd0);
    m_data = 8'h9E;
    rd(16'hDE07, "wait_rddata");

    // Reset while waiting for read data
    wr(16'hDE06, 8'h80);
    wait_req();
    pulse_gnt(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check_val("rstmid_req", 32'(o_req), 32'd0);
    check_val("rstmid_busy", 32'(o_busy), 32'd0);
    tick(2);
    rst = 1'b0;
    model_reset();
    pulse_rv(8'h5A);
    tick(1);
    check_val("rstmid_late_rv", 32'(o_busy), 32'd0);
    rd(16'hDE07, "rstmid_rddata");
    rd(16'hDE06, "rstmid_ctl");

    // Decode edges and drive-enable timing
    rd(16'hDE00, "miss_de00");
    rd(16'hDE08, "miss_de08");
    i_64addr = 16'hDE05;
    i_64rw   = 1'b1;
    tick(4);
    i_64clk = 1'b1;
    lat = 0;
    while (!o_64data_oe && lat < 8) begin
      tick(1);
      lat++;
    end
    check_val("oe_rise_lat_le3", 32'(lat <= 3), 32'd1);
    tick(5);
    check_val("oe_msb_data", 32'(o_64data), 32'((m_ptr / 256) % 256));
    i_64clk = 1'b0;
    lat = 0;
    while (o_64data_oe && lat < 8) begin
      tick(1);
      lat++;
    end
    check_val("oe_fall_lat_le3", 32'(lat <= 3), 32'd1);
    tick(4);

    // Randomised pointer/fetch traffic
    for (int it = 0; it < 12; it++) begin
      int p, ai, gd, rvd;
      p   = int'($urandom_range(0, 131071));
      ai  = int'($urandom_range(0, 1));
      gd  = int'($urandom_range(0, 6));
      rvd = int'($urandom_range(0, 3));
      rv  = 8'($urandom_range(0, 255));
      wr(16'hDE04, 8'(p % 256));
      wr(16'hDE05, 8'((p / 256) % 256));
      wr(16'hDE06, 8'(128 + ai * 2 + p / 65536));
      do_fetch(gd, rvd, rv, "rnd");
      i_gnt = 1'b1; i_rvalid = 1'b1; i_rdata = ~rv;
      tick(1);
      i_gnt = 1'b0; i_rvalid = 1'b0;
      check_val("rnd_stray", 32'(o_busy), 32'd0);
      wr(16'hDE07, 8'($urandom_range(0, 255)));
      rd(16'hDE06, "rnd_ctl");
      rd(16'hDE07, "rnd_rddata");
      if (ai == 1) begin
        do_fetch(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), "rnd_ai");
      end else begin
        tick(10);
        check_val("rnd_noai_idle", 32'(o_busy), 32'd0);
      end
      rd(16'hDE04, "rnd_lsb");
      rd(16'hDE05, "rnd_msb");
      a = 16'($urandom_range(0, 65535));
      if (a >= 16'hDE04 && a <= 16'hDE07) a = 16'hDE08;
      rd(a, "rnd_miss");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
